turn_symbol_sequencer: RTL and testbench
========================================

// Module: turn_symbol_sequencer
// PURPOSE
//   Game-status sequencer for Tic-Tac-Toe. Tracks the player to move, the move count and the game
//   outcome, and drives four 4-bit symbol codes, one per hex digit, into four player-turn 7-seg
//   decoders. Produces blinking prompts, the current player's symbol, "W i n" plus the winner,
//   and a draw pattern. It sits between the board/win-check logic and the symbol decoders.
// PARAMETERS
//   BLINK_DIV  25_000_000  clock cycles per blink half-period (>=2; bench uses 4)
// PORTS
//   clk         in   1  system clock
//   reset       in   1  synchronous, active-high reset
//   start       in   1  one-cycle pulse: begin/restart a game
//   move_done   in   1  one-cycle pulse: current player placed a legal mark
//   game_won    in   1  qualified only with move_done: that move completed a line
//   cur_player  out  1  player to move: 0 = O, 1 = X
//   move_count  out  4  marks placed this game, 0..9
//   sym3        out  4  symbol code, leftmost digit
//   sym2        out  4  symbol code
//   sym1        out  4  symbol code
//   sym0        out  4  symbol code, rightmost digit
// BEHAVIOUR
//   Symbol codes: 0=O, 1=X, 2=underscore, 3=blank, 4=W, 5=i, 6=n. No other code is ever driven.
//   Reset: state IDLE, cur_player=0, move_count=0, blink counter=0, phase=0, sym3..sym0=3.
//   Blink: counter runs 0..BLINK_DIV-1 and wraps. On wrap, phase toggles. The counter and
//     phase clear to 0 on every state change and on start.
//   All outputs are registered. They reflect an event sampled at edge N from edge N onward,
//     i.e. in the cycle after the input was high.
//   States:
//   - IDLE: sym3 = phase?3:2, sym2..0 = 3. start -> PLAY. move_done is ignored.
//   - PLAY: sym3 = {3'b0,cur_player}, sym2 = sym1 = 3, sym0 = phase?3:2 (turn cursor).
//       On move_done & game_won: WIN, winner latched = cur_player, no toggle, move_count+1.
//       On move_done & !game_won & move_count==8: DRAW, move_count=9.
//       On move_done otherwise: toggle cur_player, move_count+1.
//   - WIN: sym3 = phase?3:winner, sym2=4, sym1=5, sym0=6. cur_player and move_count hold.
//   - DRAW: all four digits = phase?3:2. cur_player and move_count hold.
//   start in any state -> PLAY, cur_player=0, move_count=0, blink cleared.
//   Priority: reset > start > move_done. start and move_done in the same cycle counts as start
//     only; the move is dropped.
//   A win on the 9th move goes to WIN, not DRAW.
//   game_won without move_done has no effect. move_done in WIN/DRAW/IDLE has no effect.
//   move_count never exceeds 9 and never wraps.
//   Reset mid-game or mid-blink returns to the reset values at the next edge.
// TESTING (BLINK_DIV=4)
//   Reset 2 cycles -> sym=3,3,3,3, cur_player=0. After 4 idle cycles sym3=2; after 4 more sym3=3.
//   start, then 3 move_done pulses -> cur_player 0->1->0->1, sym3 tracks it, move_count=3.
//     sym0 toggles 2/3 every 4 cycles.
//   start, then moves 1-4 plain and move 5 with game_won=1 -> sym={0,4,5,6}, cur_player=0,
//     move_count=5. sym3 alternates 0/3 every 4 cycles. Further move_done is ignored.
//   start, then 9 move_done with game_won=0 -> DRAW, all digits 2 then 3 every 4 cycles,
//     move_count=9. Repeat with game_won on move 9 -> WIN, sym3 = 0 (winner O).
//   In PLAY with move_count=4: assert start and move_done together -> cur_player=0, move_count=0,
//     sym3=0, blink counter restarted.
//   In WIN, assert reset 1 cycle -> next cycle IDLE, sym=3,3,3,3, move_count=0, cur_player=0.

Source files
------------

// File: rtl/turn_symbol_sequencer.sv
// Game-status sequencer for Tic-Tac-Toe: tracks turn, move count and outcome, and
// drives four registered symbol codes for the player-turn 7-segment digits.
module turn_symbol_sequencer #(
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       move_done,
   input  logic       game_won,
   output logic       cur_player,
   output logic [3:0] move_count,
   output logic [3:0] sym3,
   output logic [3:0] sym2,
   output logic [3:0] sym1,
   output logic [3:0] sym0
);

   localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   localparam logic [3:0] SYM_O     = 4'd0;
   localparam logic [3:0] SYM_X     = 4'd1;
   localparam logic [3:0] SYM_UNDER = 4'd2;
   localparam logic [3:0] SYM_BLANK = 4'd3;
   localparam logic [3:0] SYM_W     = 4'd4;
   localparam logic [3:0] SYM_I     = 4'd5;
   localparam logic [3:0] SYM_N     = 4'd6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY,
      S_WIN,
      S_DRAW
   } state_t;

   state_t          r_state,     w_state_nxt;
   logic            r_player,    w_player_nxt;
   logic   [3:0]    r_count,     w_count_nxt;
   logic            r_winner,    w_winner_nxt;
   logic   [CW-1:0] r_blink_cnt, w_blink_cnt_nxt;
   logic            r_phase,     w_phase_nxt;
   logic            w_blink_clr;
   logic   [3:0]    w_blink_sym;
   logic   [3:0]    r_sym3, r_sym2, r_sym1, r_sym0;
   logic   [3:0]    w_sym3_nxt, w_sym2_nxt, w_sym1_nxt, w_sym0_nxt;

   // Game progression: start overrides everything, moves only count while playing.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      w_state_nxt  = r_state;
      w_player_nxt = r_player;
      w_count_nxt  = r_count;
      w_winner_nxt = r_winner;
      if (start) begin
         w_state_nxt  = S_PLAY;
         w_player_nxt = 1'b0;
         w_count_nxt  = 4'd0;
      end else if (move_done && (r_state == S_PLAY)) begin
         if (game_won) begin
            w_state_nxt  = S_WIN;
            w_winner_nxt = r_player;
            w_count_nxt  = r_count + 4'd1;
         end else if (r_count == 4'd8) begin
            w_state_nxt = S_DRAW;
            w_count_nxt = 4'd9;
         end else begin
            w_player_nxt = ~r_player;
            w_count_nxt  = r_count + 4'd1;
         end
      end
   end

   // Blink timebase restarts whenever the display context changes.
   always_comb begin
      w_blink_clr     = start || (w_state_nxt != r_state);
      w_blink_cnt_nxt = r_blink_cnt + CW'(1);
      w_phase_nxt     = r_phase;
      if (w_blink_clr) begin
         w_blink_cnt_nxt = '0;
         w_phase_nxt     = 1'b0;
      end else if (r_blink_cnt == CW'(BLINK_DIV - 1)) begin
         w_blink_cnt_nxt = '0;
         w_phase_nxt     = ~r_phase;
      end
   end

   // Symbols are decoded from the next-cycle state so they change on the same edge.
   always_comb begin
      w_blink_sym = w_phase_nxt ? SYM_BLANK : SYM_UNDER;
      w_sym3_nxt  = SYM_BLANK;
      w_sym2_nxt  = SYM_BLANK;
      w_sym1_nxt  = SYM_BLANK;
      w_sym0_nxt  = SYM_BLANK;
      case (w_state_nxt)
         S_IDLE: w_sym3_nxt = w_blink_sym;
         S_PLAY: begin
            w_sym3_nxt = w_player_nxt ? SYM_X : SYM_O;
            w_sym0_nxt = w_blink_sym;
         end
         S_WIN: begin
            w_sym3_nxt = w_phase_nxt ? SYM_BLANK : (w_winner_nxt ? SYM_X : SYM_O);
            w_sym2_nxt = SYM_W;
            w_sym1_nxt = SYM_I;
            w_sym0_nxt = SYM_N;
         end
         S_DRAW: begin
            w_sym3_nxt = w_blink_sym;
            w_sym2_nxt = w_blink_sym;
            w_sym1_nxt = w_blink_sym;
            w_sym0_nxt = w_blink_sym;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         r_state     <= S_IDLE;
         r_player    <= 1'b0;
         r_count     <= 4'd0;
         r_winner    <= 1'b0;
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
         r_sym3      <= SYM_BLANK;
         r_sym2      <= SYM_BLANK;
         r_sym1      <= SYM_BLANK;
         r_sym0      <= SYM_BLANK;
      end else begin
         r_state     <= w_state_nxt;
         r_player    <= w_player_nxt;
         r_count     <= w_count_nxt;
         r_winner    <= w_winner_nxt;
         r_blink_cnt <= w_blink_cnt_nxt;
         r_phase     <= w_phase_nxt;
         r_sym3      <= w_sym3_nxt;
         r_sym2      <= w_sym2_nxt;
         r_sym1      <= w_sym1_nxt;
         r_sym0      <= w_sym0_nxt;
      end
   end

   assign cur_player = r_player;
   assign move_count = r_count;
   assign sym3       = r_sym3;
   assign sym2       = r_sym2;
   assign sym1       = r_sym1;
   assign sym0       = r_sym0;

endmodule

// File: tb/tb_turn_symbol_sequencer.sv
// Self-checking bench for turn_symbol_sequencer: directed game scenarios followed by
// random pulses, every cycle compared against a game-level reference model.
module tb_turn_symbol_sequencer;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       reset, start, move_done, game_won;
   logic       cur_player;
   logic [3:0] move_count, sym3, sym2, sym1, sym0;

   int checks = 0;
   int errors = 0;

   // Reference model: game status plus edges elapsed since the blink was last cleared.
   typedef enum {M_IDLE, M_PLAY, M_WIN, M_DRAW} mstate_t;
   mstate_t m_state;
   int      m_player, m_count, m_winner, m_ticks;
   bit      m_fresh;

   turn_symbol_sequencer #(.BLINK_DIV(DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .move_done  (move_done),
      .game_won   (game_won),
      .cur_player (cur_player),
      .move_count (move_count),
      .sym3       (sym3),
      .sym2       (sym2),
      .sym1       (sym1),
      .sym0       (sym0)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   function automatic int blink_sym();
      return (((m_ticks / DIV) % 2) == 1) ? 3 : 2;
   endfunction

   task automatic model_edge(input bit r, input bit s, input bit mv, input bit w);
      mstate_t prev;
      bit      clr;
      if (r) begin
         m_state = M_IDLE; m_player = 0; m_count = 0; m_winner = 0;
         m_ticks = 0; m_fresh = 1'b1;
         return;
      end
      m_fresh = 1'b0;
      prev    = m_state;
      clr     = 1'b0;
      if (s) begin
         m_state = M_PLAY; m_player = 0; m_count = 0; clr = 1'b1;
      end else if (mv && m_state == M_PLAY) begin
         if (w) begin
            m_state = M_WIN; m_winner = m_player; m_count++;
         end else if (m_count == 8) begin
            m_state = M_DRAW; m_count = 9;
         end else begin
            m_player = 1 - m_player; m_count++;
         end
      end
      if (clr || m_state != prev) m_ticks = 0;
      else m_ticks++;
   endtask

   task automatic compare_outputs();
      int e3, e2, e1, e0;
      e3 = 3; e2 = 3; e1 = 3; e0 = 3;
      if (!m_fresh) begin
         case (m_state)
            M_IDLE: e3 = blink_sym();
            M_PLAY: begin e3 = m_player; e0 = blink_sym(); end
            M_WIN:  begin
               e3 = (blink_sym() == 3) ? 3 : m_winner;
               e2 = 4; e1 = 5; e0 = 6;
            end
            M_DRAW: begin e3 = blink_sym(); e2 = e3; e1 = e3; e0 = e3; end
            default: ;
         endcase
      end
      check("cur_player", int'(cur_player), m_player);
      check("move_count", int'(move_count), m_count);
      check("sym3", int'(sym3), e3);
      check("sym2", int'(sym2), e2);
      check("sym1", int'(sym1), e1);
      check("sym0", int'(sym0), e0);
   endtask

   // One clock: drive pulses, advance model at the edge, compare on the falling edge.
   task automatic step(input bit r, input bit s, input bit mv, input bit w);
      reset = r; start = s; move_done = mv; game_won = w;
      @(posedge clk);
      model_edge(r, s, mv, w);
      @(negedge clk);
      reset = 1'b0; start = 1'b0; move_done = 1'b0; game_won = 1'b0;
      compare_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic moves(input int n, input bit win_last);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, 1'b1, (i == n - 1) && win_last);
         idle(1);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; move_done = 1'b0; game_won = 1'b0;
      m_state = M_IDLE; m_player = 0; m_count = 0; m_winner = 0; m_ticks = 0; m_fresh = 1'b1;
      @(negedge clk);

      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(9);
      step(1'b0, 1'b0, 1'b1, 1'b1);            // move ignored in IDLE
      idle(2);

      step(1'b0, 1'b1, 1'b0, 1'b0);            // three plain moves
      moves(3, 1'b0);
      idle(9);

      step(1'b0, 1'b1, 1'b0, 1'b0);            // O wins on move 5
      moves(5, 1'b1);
      idle(9);
      moves(2, 1'b0);

      step(1'b0, 1'b1, 1'b0, 1'b0);            // full board draw
      moves(9, 1'b0);
      idle(9);
      moves(1, 1'b1);

      step(1'b0, 1'b1, 1'b0, 1'b0);            // win on the ninth move
      moves(9, 1'b1);
      idle(6);

      step(1'b0, 1'b1, 1'b0, 1'b0);            // start beats a simultaneous move
      moves(4, 1'b0);
      idle(2);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      idle(5);
      step(1'b0, 1'b0, 1'b0, 1'b1);            // game_won alone has no effect
      idle(2);

      moves(2, 1'b1);                          // reset out of WIN
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);

      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 5) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
